// File: rtl/golden_nonce_arbiter.sv
// Golden-nonce collector: per-core holding slots, round-robin arbiter into a
// first-word-fall-through FIFO that drains to the serial TX path.
module golden_nonce_arbiter #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CORE_W     = 2
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    input  logic [NUM_CORES-1:0]    core_match,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    input  logic                    work_load,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [31:0]             tx_nonce,
    output logic [CORE_W-1:0]       tx_core,
    output logic                    fifo_full,
    output logic [7:0]              drop_count
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENTRY_W = CORE_W + 32;
    localparam logic [PTR_W:0]      FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CORE_W-1:0]   LAST_CORE = CORE_W'(NUM_CORES - 1);

    logic [NUM_CORES-1:0] slot_valid;
    logic [31:0]          slot_nonce [NUM_CORES];
    logic [CORE_W-1:0]    rr_ptr;

    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_count;
    logic [ENTRY_W-1:0]   head;

    logic                 grant_any;
    logic                 grant;
    logic [CORE_W-1:0]    grant_idx;
    logic                 pop;
    logic                 fifo_space;
    logic [NUM_CORES-1:0] slot_load;
    logic [NUM_CORES-1:0] slot_clear;
    logic [NUM_CORES-1:0] slot_drop;
    logic [3:0]           drop_inc;
    logic [8:0]           drop_sum;

    assign tx_valid   = (fifo_count != '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign head       = fifo_mem[rd_ptr];
    assign tx_nonce   = tx_valid ? head[31:0] : '0;
    assign tx_core    = tx_valid ? head[ENTRY_W-1:32] : '0;
    assign pop        = tx_valid & tx_ready;
    // A pop in the same cycle frees the entry a grant needs, so full is not a stall then.
    assign fifo_space = !fifo_full || pop;
    assign grant      = grant_any && fifo_space;

    // Round-robin pick: first occupied slot at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_CORES;
            if (!grant_any && slot_valid[CORE_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = CORE_W'(cand);
            end
        end
    end

    // Per-slot capture/clear/drop decisions; a granted slot may reload in the same cycle.
    always_comb begin
        logic granted;
        slot_load  = '0;
        slot_clear = '0;
        slot_drop  = '0;
        drop_inc   = '0;
        granted    = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            granted       = grant && (grant_idx == CORE_W'(i));
            slot_clear[i] = granted;
            slot_load[i]  = core_match[i] && (!slot_valid[i] || granted);
            slot_drop[i]  = core_match[i] && slot_valid[i] && !granted;
            drop_inc      = drop_inc + 4'(slot_drop[i]);
        end
        drop_sum = 9'(drop_count) + 9'(drop_inc);
    end

    // Control state: reset, flush, then normal slot/arbiter/FIFO bookkeeping.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else if (work_load) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            slot_valid <= (slot_valid & ~slot_clear) | slot_load;
            if (grant) begin
                rr_ptr <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (grant && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!grant && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    // Data storage: slot nonces and FIFO entries; validity is tracked by the control state.
    always_ff @(posedge hash_clk) begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (slot_load[i]) begin
                slot_nonce[i] <= core_nonce[32*i +: 32];
            end
        end
        if (grant) begin
            fifo_mem[wr_ptr] <= {grant_idx, slot_nonce[grant_idx]};
        end
    end

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Scoreboard bench for golden_nonce_arbiter: stimulus queues expected words,
// a negedge monitor checks every accepted TX word against the queue.
module tb_golden_nonce_arbiter;

    logic         hash_clk = 1'b0;
    logic         reset_n;
    logic [3:0]   core_match;
    logic [127:0] core_nonce;
    logic         work_load;
    logic         tx_ready;
    logic         tx_valid;
    logic [31:0]  tx_nonce;
    logic [1:0]   tx_core;
    logic         fifo_full;
    logic [7:0]   drop_count;

    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    golden_nonce_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(8), .CORE_W(2)) dut (
        .hash_clk   (hash_clk),
        .reset_n    (reset_n),
        .core_match (core_match),
        .core_nonce (core_nonce),
        .work_load  (work_load),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_nonce   (tx_nonce),
        .tx_core    (tx_core),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 hash_clk = ~hash_clk;

    // Monitor: every word accepted by TX must match the head of the scoreboard.
    always @(negedge hash_clk) begin
        logic [33:0] e;
        if (reset_n && !work_load && tx_valid && tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL word: got core=%0d nonce=%h, expected no word", tx_core, tx_nonce);
            end else begin
                e = exp_q.pop_front();
                if ({tx_core, tx_nonce} !== e) begin
                    fails++;
                    $display("FAIL word: got core=%0d nonce=%h, expected core=%0d nonce=%h",
                             tx_core, tx_nonce, e[33:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int core, input logic [31:0] nonce);
        exp_q.push_back({2'(core), nonce});
    endtask

    task automatic set_nonce(input int core, input logic [31:0] nonce);
        core_nonce[32*core +: 32] = nonce;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic flush();
        work_load = 1'b1;
        tick();
        work_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"},   32'(tx_valid),   32'd0);
        check({tag, " tx_nonce"},   tx_nonce,        32'd0);
        check({tag, " tx_core"},    32'(tx_core),    32'd0);
        check({tag, " fifo_full"},  32'(fifo_full),  32'd0);
        check({tag, " drop_count"}, 32'(drop_count), 32'd0);
    endtask

    // Fairness pattern: cores 1 and 3 reload exactly when their slot is granted.
    logic [3:0]  t3_match [5] = '{4'b1010, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [31:0] t3_n1    [5] = '{32'hB100_0000, 32'hB100_0001, 32'h0, 32'hB100_0002, 32'h0};
    logic [31:0] t3_n3    [5] = '{32'hB300_0000, 32'h0, 32'hB300_0001, 32'h0, 32'hB300_0002};

    initial begin
        reset_n    = 1'b0;
        core_match = '0;
        core_nonce = '0;
        work_load  = 1'b0;
        tx_ready   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check_reset_outputs("reset");

        // 1: single hit, two-edge latency
        set_nonce(0, 32'h0000_1234);
        core_match = 4'b0001;
        expect_word(0, 32'h0000_1234);
        tick();
        core_match = '0;
        check("t1 valid after capture edge", 32'(tx_valid), 32'd0);
        tick();
        check("t1 valid after push edge", 32'(tx_valid), 32'd1);
        check("t1 nonce", tx_nonce, 32'h0000_1234);
        check("t1 core", 32'(tx_core), 32'd0);
        tx_ready = 1'b1;
        tick();
        check("t1 valid after pop", 32'(tx_valid), 32'd0);
        check("t1 drained", 32'(exp_q.size()), 32'd0);

        // 2: all four cores in one cycle, rr reset to 0 by flush
        flush();
        for (int i = 0; i < 4; i++) begin
            set_nonce(i, 32'hA0 + 32'(i));
            expect_word(i, 32'hA0 + 32'(i));
        end
        core_match = 4'b1111;
        tick();
        core_match = '0;
        drain("t2 drain");
        check("t2 drop_count", 32'(drop_count), 32'd0);

        // 3: round-robin fairness between cores 1 and 3
        flush();
        for (int r = 0; r < 3; r++) begin
            expect_word(1, 32'hB100_0000 + 32'(r));
            expect_word(3, 32'hB300_0000 + 32'(r));
        end
        for (int k = 0; k < 5; k++) begin
            core_match = t3_match[k];
            if (t3_match[k][1]) set_nonce(1, t3_n1[k]);
            if (t3_match[k][3]) set_nonce(3, t3_n3[k]);
            tick();
        end
        core_match = '0;
        drain("t3 drain");
        check("t3 drop_count", 32'(drop_count), 32'd0);

        // 4: backpressure, 8 in FIFO + 4 in slots, one drop
        tx_ready = 1'b0;
        flush();
        for (int k = 0; k < 12; k++) begin
            core_match = 4'(1 << (k % 4));
            set_nonce(k % 4, 32'hD000_0000 + 32'(k));
            expect_word(k % 4, 32'hD000_0000 + 32'(k));
            tick();
        end
        core_match = '0;
        check("t4 fifo_full", 32'(fifo_full), 32'd1);
        check("t4 head nonce", tx_nonce, 32'hD000_0000);
        check("t4 drop before repeat", 32'(drop_count), 32'd0);
        set_nonce(2, 32'hDEAD_0002);
        core_match = 4'b0100;
        tick();
        core_match = '0;
        check("t4 drop_count", 32'(drop_count), 32'd1);
        check("t4 still full", 32'(fifo_full), 32'd1);
        tx_ready = 1'b1;
        drain("t4 drain");
        check("t4 drop after drain", 32'(drop_count), 32'd1);
        check("t4 fifo_full after drain", 32'(fifo_full), 32'd0);

        // 5: flush with 3 words queued and a concurrent hit from core 1
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_nonce(i, 32'hE000_0000 + 32'(i));
        core_match = 4'b0111;
        tick();
        core_match = '0;
        repeat (3) tick();
        check("t5 valid before flush", 32'(tx_valid), 32'd1);
        check("t5 head before flush", tx_nonce, 32'hE000_0000);
        set_nonce(1, 32'hE111_1111);
        core_match = 4'b0010;
        work_load  = 1'b1;
        tx_ready   = 1'b1;
        tick();
        core_match = '0;
        work_load  = 1'b0;
        check("t5 valid after flush", 32'(tx_valid), 32'd0);
        check("t5 fifo_full after flush", 32'(fifo_full), 32'd0);
        check("t5 drop_count", 32'(drop_count), 32'd1);
        repeat (4) tick();
        check("t5 core1 hit absent", 32'(tx_valid), 32'd0);

        // 6: reset mid-transfer, then a normal hit
        tx_ready = 1'b0;
        set_nonce(2, 32'hF000_0000);
        core_match = 4'b0100;
        tick();
        core_match = '0;
        tick();
        check("t6 valid before reset", 32'(tx_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset_outputs("t6 reset");
        set_nonce(3, 32'hF000_0001);
        core_match = 4'b1000;
        expect_word(3, 32'hF000_0001);
        tick();
        core_match = '0;
        tx_ready = 1'b1;
        drain("t6 drain");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
